// File: rtl/ws_stream_ctrl_if.sv
// Host-side bus between the stream controller and one pio instance.
// The master drives program/config/FIFO writes; the slave reports the per-SM TX-full flags.
interface ws_stream_ctrl_if;
    logic [31:0] pio_din;
    logic [4:0]  pio_index;
    logic [3:0]  pio_action;
    logic [1:0]  pio_mindex;
    logic [3:0]  pio_full;

    modport master (
        output pio_din,
        output pio_index,
        output pio_action,
        output pio_mindex,
        input  pio_full
    );

    modport slave (
        input  pio_din,
        input  pio_index,
        input  pio_action,
        input  pio_mindex,
        output pio_full
    );
endinterface

// File: rtl/ws_stream_ctrl.sv
// Loads the pio program and configuration after reset, then streams a brightness-scaled
// pixel buffer into one state machine's TX FIFO with a latch gap after every frame.
//
// state    | meaning
// S_LOAD   | write PROG_LEN program words (action 1)
// S_CONF   | apply CONF_LEN configuration words from the config ROM
// S_IDLE   | configured, waiting for start or cont
// S_STREAM | push pixels 0..NUM_PIX-1, one push at most every other cycle
// S_GAP    | GAP_CYCLES latch gap, frame_done on the final cycle
module ws_stream_ctrl #(
    parameter int PROG_LEN   = 32,
    parameter int CONF_LEN   = 6,
    parameter int NUM_PIX    = 16,
    parameter int MINDEX     = 0,
    parameter int GAP_CYCLES = 2000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [4:0]             prog_addr_o,
    input  logic [15:0]            prog_data_i,
    output logic [4:0]             conf_addr_o,
    input  logic [35:0]            conf_data_i,
    input  logic                   pix_we_i,
    input  logic [7:0]             pix_waddr_i,
    input  logic [23:0]            pix_wdata_i,
    input  logic [7:0]             brightness_i,
    input  logic                   start_i,
    input  logic                   cont_i,
    ws_stream_ctrl_if.master       pio,
    output logic                   cfg_done_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [15:0]            stall_cnt_o
);

    localparam int         PW    = $clog2(NUM_PIX);
    localparam int         GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [8:0] NPIX9 = 9'(NUM_PIX);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CONF,
        S_IDLE,
        S_STREAM,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [PW-1:0]   p_q, p_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            pushed_q, pushed_d;
    logic            cfg_done_q, cfg_done_d;
    logic            frame_done_q, frame_done_d;
    logic [15:0]     stall_q, stall_d;
    logic [3:0]      action_q, action_d;
    logic [31:0]     din_q, din_d;
    logic [4:0]      index_q, index_d;

    logic [23:0]     pix_mem [NUM_PIX];
    logic [23:0]     pix_rd;
    logic            full_m;

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = 17'(c) * 17'({1'b0, b} + 9'd1);
        return 8'(prod >> 8);
    endfunction

    // Buffer is not reset; the push reads the pre-write value on an address collision.
    always_ff @(posedge clk_i) begin
        if (pix_we_i && ({1'b0, pix_waddr_i} < NPIX9)) begin
            pix_mem[pix_waddr_i[PW-1:0]] <= pix_wdata_i;
        end
    end

    assign pix_rd = pix_mem[p_q];
    assign full_m = |(pio.pio_full & (4'b0001 << MINDEX));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        p_d          = p_q;
        gap_d        = gap_q;
        pushed_d     = 1'b0;
        cfg_done_d   = cfg_done_q;
        frame_done_d = 1'b0;
        stall_d      = stall_q;
        action_d     = 4'd0;
        din_d        = din_q;
        index_d      = index_q;

        case (state_q)
            S_LOAD: begin
                action_d = 4'd1;
                din_d    = {16'h0000, prog_data_i};
                index_d  = idx_q;
                if (idx_q == 5'(PROG_LEN - 1)) begin
                    idx_d   = 5'd0;
                    state_d = S_CONF;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_CONF: begin
                action_d = conf_data_i[35:32];
                din_d    = conf_data_i[31:0];
                if (idx_q == 5'(CONF_LEN - 1)) begin
                    idx_d   = 5'd0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_IDLE: begin
                cfg_done_d = 1'b1;
                if (start_i || cont_i) begin
                    p_d     = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (full_m && (stall_q != 16'hFFFF)) begin
                    stall_d = stall_q + 16'd1;
                end
                // Skipping the cycle after a push covers the one-cycle lag of the full flag.
                if (!full_m && !pushed_q) begin
                    action_d = 4'd4;
                    din_d    = {scale_ch(pix_rd[23:16], brightness_i),
                                scale_ch(pix_rd[15:8], brightness_i),
                                scale_ch(pix_rd[7:0], brightness_i), 8'h00};
                    pushed_d = 1'b1;
                    if (p_q == PW'(NUM_PIX - 1)) begin
                        p_d     = '0;
                        gap_d   = GW'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    frame_done_d = 1'b1;
                    p_d          = '0;
                    state_d      = cont_i ? S_STREAM : S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_LOAD;
            idx_q        <= 5'd0;
            p_q          <= '0;
            gap_q        <= '0;
            pushed_q     <= 1'b0;
            cfg_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            stall_q      <= 16'd0;
            action_q     <= 4'd0;
            din_q        <= 32'd0;
            index_q      <= 5'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            p_q          <= p_d;
            gap_q        <= gap_d;
            pushed_q     <= pushed_d;
            cfg_done_q   <= cfg_done_d;
            frame_done_q <= frame_done_d;
            stall_q      <= stall_d;
            action_q     <= action_d;
            din_q        <= din_d;
            index_q      <= index_d;
        end
    end

    assign prog_addr_o    = (state_q == S_LOAD) ? idx_q : 5'd0;
    assign conf_addr_o    = (state_q == S_CONF) ? idx_q : 5'd0;
    assign pio.pio_din    = din_q;
    assign pio.pio_index  = index_q;
    assign pio.pio_action = action_q;
    assign pio.pio_mindex = 2'(MINDEX);
    assign cfg_done_o     = cfg_done_q;
    assign busy_o         = (state_q == S_STREAM) || (state_q == S_GAP);
    assign frame_done_o   = frame_done_q;
    assign stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_ws_stream_ctrl.sv
// Directed bench for ws_stream_ctrl: program/config load, frame streaming, scaling,
// back-pressure, write collision, start filtering, continuous mode and mid-frame reset.
module tb_ws_stream_ctrl;

    localparam int GAP = 20;

    logic        clk, rst;
    logic [4:0]  prog_addr, conf_addr;
    logic [15:0] prog_data;
    logic [35:0] conf_data;
    logic        pix_we, start, cont;
    logic [7:0]  pix_waddr, brightness;
    logic [23:0] pix_wdata;
    logic        cfg_done, busy, frame_done;
    logic [15:0] stall_cnt;

    ws_stream_ctrl_if pio_if();

    ws_stream_ctrl #(
        .PROG_LEN(32), .CONF_LEN(6), .NUM_PIX(4), .MINDEX(1), .GAP_CYCLES(GAP)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .prog_addr_o(prog_addr), .prog_data_i(prog_data),
        .conf_addr_o(conf_addr), .conf_data_i(conf_data),
        .pix_we_i(pix_we), .pix_waddr_i(pix_waddr), .pix_wdata_i(pix_wdata),
        .brightness_i(brightness), .start_i(start), .cont_i(cont),
        .pio(pio_if.master),
        .cfg_done_o(cfg_done), .busy_o(busy), .frame_done_o(frame_done),
        .stall_cnt_o(stall_cnt)
    );

    logic [35:0] conf_rom [6] = '{36'h2_1111_0000, 36'h3_2222_0001, 36'h5_3333_0002,
                                  36'h6_4444_0003, 36'h7_5555_0004, 36'h8_6666_0005};
    logic [3:0]  exp_act [6]  = '{4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [31:0] exp_cd  [6]  = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002,
                                  32'h4444_0003, 32'h5555_0004, 32'h6666_0005};
    logic [31:0] exp255  [4]  = '{32'h00FF0000, 32'hFF00FF00, 32'h12345600, 32'hABCDEF00};
    logic [23:0] pix_init[4]  = '{24'h00FF00, 24'hFF00FF, 24'h123456, 24'hABCDEF};

    assign prog_data = 16'h1000 + {11'd0, prog_addr};
    assign conf_data = (conf_addr < 5'd6) ? conf_rom[conf_addr[2:0]] : 36'd0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] cap_w [16];
    int          cap_c [16];
    int          done_c [4];
    int          cap_n, done_n, cap_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic clear_cap();
        cap_n = 0; done_n = 0; cap_t = 0;
    endtask

    task automatic collect(input int nframes, input int budget, output bit ok);
        int target;
        target = done_n + nframes;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pio_if.pio_action == 4'd4 && cap_n < 16) begin
                cap_w[cap_n] = pio_if.pio_din; cap_c[cap_n] = cap_t; cap_n++;
            end
            if (frame_done === 1'b1 && done_n < 4) begin
                done_c[done_n] = cap_t; done_n++;
            end
            cap_t++;
            if (done_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic write_pix(input logic [7:0] a, input logic [23:0] d);
        pix_we = 1'b1; pix_waddr = a; pix_wdata = d;
        @(negedge clk);
        pix_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_we = 1'b0; pix_waddr = '0; pix_wdata = '0; brightness = 8'd255;
        start = 1'b0; cont = 1'b0; pio_if.pio_full = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++; if (pio_if.pio_action !== 4'd0) $display("FAIL reset_action got %h exp 0", pio_if.pio_action); else n_pass++;
        n_checks++; if (pio_if.pio_din !== 32'd0) $display("FAIL reset_din got %h exp 0", pio_if.pio_din); else n_pass++;
        n_checks++; if (pio_if.pio_index !== 5'd0) $display("FAIL reset_index got %h exp 0", pio_if.pio_index); else n_pass++;
        n_checks++; if (pio_if.pio_mindex !== 2'd1) $display("FAIL reset_mindex got %h exp 1", pio_if.pio_mindex); else n_pass++;
        n_checks++; if ({cfg_done, busy, frame_done} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {cfg_done, busy, frame_done}); else n_pass++;
        n_checks++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall got %h exp 0", stall_cnt); else n_pass++;
        n_checks++; if (prog_addr !== 5'd0) $display("FAIL reset_prog_addr got %h exp 0", prog_addr); else n_pass++;
    endtask

    task automatic test_load();
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_checks++; if (pio_if.pio_action !== 4'd1) $display("FAIL load_action k=%0d got %h exp 1", k, pio_if.pio_action); else n_pass++;
            n_checks++; if (pio_if.pio_index !== 5'(k)) $display("FAIL load_index k=%0d got %0d exp %0d", k, pio_if.pio_index, k); else n_pass++;
            n_checks++; if (pio_if.pio_din !== 32'h1000 + 32'(k)) $display("FAIL load_din k=%0d got %h exp %h", k, pio_if.pio_din, 32'h1000 + 32'(k)); else n_pass++;
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            n_checks++; if (pio_if.pio_action !== exp_act[j]) $display("FAIL conf_action j=%0d got %h exp %h", j, pio_if.pio_action, exp_act[j]); else n_pass++;
            n_checks++; if (pio_if.pio_din !== exp_cd[j]) $display("FAIL conf_din j=%0d got %h exp %h", j, pio_if.pio_din, exp_cd[j]); else n_pass++;
            n_checks++; if (cfg_done !== 1'b0) $display("FAIL conf_cfg_done_early j=%0d got %b exp 0", j, cfg_done); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (pio_if.pio_action !== 4'd0) $display("FAIL idle_action got %h exp 0", pio_if.pio_action); else n_pass++;
        n_checks++; if (cfg_done !== 1'b1) $display("FAIL cfg_done got %b exp 1", cfg_done); else n_pass++;
        for (int i = 0; i < 4; i++) write_pix(8'(i), pix_init[i]);
    endtask

    task automatic test_frame();
        bit ok;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL frame_busy got %b exp 1", busy); else n_pass++;
        clear_cap();
        collect(1, 100, ok);
        n_checks++; if (!ok) $display("FAIL frame_timeout got no frame_done exp one"); else n_pass++;
        n_checks++; if (cap_n !== 4) $display("FAIL frame_push_count got %0d exp 4", cap_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_w[i] !== exp255[i]) $display("FAIL frame_word i=%0d got %h exp %h", i, cap_w[i], exp255[i]); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (cap_c[i+1] - cap_c[i] !== 2) $display("FAIL frame_spacing i=%0d got %0d exp 2", i, cap_c[i+1] - cap_c[i]); else n_pass++;
        end
        n_checks++; if (done_c[0] - cap_c[3] !== GAP) $display("FAIL frame_gap got %0d exp %0d", done_c[0] - cap_c[3], GAP); else n_pass++;
        @(negedge clk);
        n_checks++; if (frame_done !== 1'b0) $display("FAIL frame_done_width got %b exp 0", frame_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL frame_idle_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_scale();
        bit ok;
        logic [31:0] exp127 [4];
        exp127 = '{32'h7F400000, 32'h7F007F00, 32'h091A2B00, 32'h55667700};
        write_pix(8'd0, 24'hFF8001);
        brightness = 8'd127;
        pulse_start(); clear_cap(); collect(1, 100, ok);
        n_checks++; if (!ok || cap_n !== 4) $display("FAIL scale127_frame got ok=%0d pushes=%0d exp ok=1 pushes=4", ok, cap_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_w[i] !== exp127[i]) $display("FAIL scale127_word i=%0d got %h exp %h", i, cap_w[i], exp127[i]); else n_pass++;
        end
        brightness = 8'd0;
        pulse_start(); clear_cap(); collect(1, 100, ok);
        n_checks++; if (!ok || cap_n !== 4) $display("FAIL scale0_frame got ok=%0d pushes=%0d exp ok=1 pushes=4", ok, cap_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_w[i] !== 32'd0) $display("FAIL scale0_word i=%0d got %h exp 0", i, cap_w[i]); else n_pass++;
        end
        brightness = 8'd255;
        write_pix(8'd0, pix_init[0]);
    endtask

    task automatic test_stall();
        bit ok;
        int exp_c [4];
        exp_c = '{0, 2, 13, 15};
        pio_if.pio_full = 4'b0001;
        pulse_start(); clear_cap();
        fork
            collect(1, 100, ok);
            begin
                repeat (3) @(negedge clk);
                pio_if.pio_full = 4'b0011;
                repeat (10) @(negedge clk);
                pio_if.pio_full = 4'b0001;
            end
        join
        n_checks++; if (!ok || cap_n !== 4) $display("FAIL stall_frame got ok=%0d pushes=%0d exp ok=1 pushes=4", ok, cap_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_w[i] !== exp255[i]) $display("FAIL stall_word i=%0d got %h exp %h", i, cap_w[i], exp255[i]); else n_pass++;
            n_checks++; if (cap_c[i] !== exp_c[i]) $display("FAIL stall_push_cycle i=%0d got %0d exp %0d", i, cap_c[i], exp_c[i]); else n_pass++;
        end
        n_checks++; if (stall_cnt !== 16'd10) $display("FAIL stall_cnt got %0d exp 10", stall_cnt); else n_pass++;
        pio_if.pio_full = 4'b0000;
    endtask

    task automatic test_write_collision();
        bit ok;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pix_we = 1'b1; pix_waddr = 8'd0; pix_wdata = 24'h445566;
        @(negedge clk);
        pix_we = 1'b0;
        n_checks++; if (pio_if.pio_action !== 4'd4 || pio_if.pio_din !== exp255[0]) $display("FAIL collide_old got act=%h din=%h exp act=4 din=%h", pio_if.pio_action, pio_if.pio_din, exp255[0]); else n_pass++;
        clear_cap(); collect(1, 100, ok);
        n_checks++; if (!ok || cap_n !== 3 || cap_w[0] !== exp255[1]) $display("FAIL collide_rest got ok=%0d pushes=%0d w0=%h exp ok=1 pushes=3 w0=%h", ok, cap_n, cap_w[0], exp255[1]); else n_pass++;
        pulse_start(); clear_cap(); collect(1, 100, ok);
        n_checks++; if (!ok || cap_w[0] !== 32'h44556600) $display("FAIL collide_new got ok=%0d w0=%h exp 44556600", ok, cap_w[0]); else n_pass++;
        write_pix(8'd0, pix_init[0]);
    endtask

    task automatic test_start_ignored();
        bit seen;
        int bad;
        pulse_start();
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || pio_if.pio_action !== 4'd0) $display("FAIL ign_in_gap got busy=%b act=%h exp busy=1 act=0", busy, pio_if.pio_action); else n_pass++;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL ign_timeout got no frame_done exp one"); else n_pass++;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || pio_if.pio_action === 4'd4) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL ign_queued_start got %0d active cycles exp 0", bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int bad;
        cont = 1'b1;
        clear_cap();
        collect(2, 200, ok1);
        cont = 1'b0;
        collect(1, 200, ok2);
        n_checks++; if (!ok1 || !ok2 || done_n !== 3) $display("FAIL cont_frames got ok=%0d%0d dones=%0d exp ok=11 dones=3", ok1, ok2, done_n); else n_pass++;
        n_checks++; if (cap_n !== 12) $display("FAIL cont_push_count got %0d exp 12", cap_n); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (cap_w[i] !== exp255[i % 4]) $display("FAIL cont_word i=%0d got %h exp %h", i, cap_w[i], exp255[i % 4]); else n_pass++;
        end
        for (int f = 0; f < 3; f++) begin
            n_checks++; if (done_c[f] - cap_c[4*f+3] !== GAP) $display("FAIL cont_gap f=%0d got %0d exp %0d", f, done_c[f] - cap_c[4*f+3], GAP); else n_pass++;
        end
        for (int f = 0; f < 2; f++) begin
            n_checks++; if (cap_c[4*f+4] - done_c[f] !== 1) $display("FAIL cont_restart f=%0d got %0d exp 1", f, cap_c[4*f+4] - done_c[f]); else n_pass++;
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || pio_if.pio_action === 4'd4) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL cont_stop got %0d active cycles exp 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        pulse_start();
        repeat (3) @(negedge clk);
        n_checks++; if (pio_if.pio_action !== 4'd4 || pio_if.pio_din !== exp255[1]) $display("FAIL mid_pos got act=%h din=%h exp act=4 din=%h", pio_if.pio_action, pio_if.pio_din, exp255[1]); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (pio_if.pio_action !== 4'd0 || pio_if.pio_din !== 32'd0) $display("FAIL mid_async_pio got act=%h din=%h exp 0 0", pio_if.pio_action, pio_if.pio_din); else n_pass++;
        n_checks++; if ({cfg_done, busy} !== 2'b00 || stall_cnt !== 16'd0) $display("FAIL mid_async_flags got cfg=%b busy=%b stall=%0d exp 0 0 0", cfg_done, busy, stall_cnt); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (pio_if.pio_action !== 4'd1 || pio_if.pio_index !== 5'(k) || pio_if.pio_din !== 32'h1000 + 32'(k))
                $display("FAIL reload k=%0d got act=%h idx=%0d din=%h exp 1 %0d %h", k, pio_if.pio_action, pio_if.pio_index, pio_if.pio_din, k, 32'h1000 + 32'(k));
            else n_pass++;
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL reload_cfg_done got 0 exp 1"); else n_pass++;
        pulse_start(); clear_cap(); collect(1, 100, ok);
        n_checks++; if (!ok || cap_n !== 4) $display("FAIL reload_frame got ok=%0d pushes=%0d exp ok=1 pushes=4", ok, cap_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_w[i] !== exp255[i]) $display("FAIL reload_word i=%0d got %h exp %h", i, cap_w[i], exp255[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_frame();
        test_scale();
        test_stall();
        test_write_collision();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
